wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 138 +++++++++++++
 tb/tb_wide_add_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: registers two W-bit operands and sums them one word per cycle
// through an external word adder. Define WIDE_ADD_SEQ_SUB_EN to add the in_sub (A-B) mode.
module wide_add_seq #(
  parameter int DATA_WIDTH = 31,
  parameter int NUM_WORDS  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  // Both handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its data stable while valid is high and ready is low.
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]   in_a,
  input  logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]   in_b,
  input  logic                                  in_cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic                                  in_sub,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]   out_sum,
  output logic                                  out_cout,
  output logic                                  busy,
  output logic [DATA_WIDTH:0]                   add_a,
  output logic [DATA_WIDTH:0]                   add_b,
  output logic                                  add_cin,
  input  logic [DATA_WIDTH:0]                   add_s,
  input  logic                                  add_cout,
  output logic [1:0]                            dbg_state
);

  localparam int WB = DATA_WIDTH + 1;
  localparam int W  = NUM_WORDS * WB;
  localparam int KW = $clog2(NUM_WORDS) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          ready_en_q;

  logic [W-1:0]  b_cap;
  logic          c_cap;
  logic [WB-1:0] word_a, word_b;
  logic          last_word;

`ifdef WIDE_ADD_SEQ_SUB_EN
  // Subtraction is A + ~B + 1, so the carry-out doubles as "no borrow".
  assign b_cap = in_sub ? ~in_b : in_b;
  assign c_cap = in_sub | in_cin;
`else
  assign b_cap = in_b;
  assign c_cap = in_cin;
`endif

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (k_q == KW'(i)) begin
        word_a = a_q[i*WB +: WB];
        word_b = b_q[i*WB +: WB];
      end
    end
  end

  assign last_word = (k_q == KW'(NUM_WORDS - 1));

  // ready_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign add_a     = (state_q == S_RUN) ? word_a  : '0;
  assign add_b     = (state_q == S_RUN) ? word_b  : '0;
  assign add_cin   = (state_q == S_RUN) ? carry_q : 1'b0;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = b_cap;
          carry_d = c_cap;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (k_q == KW'(i)) sum_d[i*WB +: WB] = add_s;
        end
        carry_d = add_cout;
        k_d     = k_q + KW'(1);
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed corner cases plus randomized requests with output
// backpressure, scored against a wide-integer reference of A+B+cin (or A-B).
module tb_wide_add_seq;

  localparam int DW = 31;
  localparam int NW = 4;
  localparam int WB = DW + 1;
  localparam int W  = NW * WB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          busy;
  logic [WB-1:0] add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  // External word adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WB{1'b0}}, add_cin};

  wide_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .busy(busy),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_s(add_s),
    .add_cout(add_cout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
    logic [W:0] r;
    logic [W:0] c1;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      c1 = '0;
      c1[0] = cin;
      r = {1'b0, a} + {1'b0, b} + c1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WB +: WB] = $urandom;
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r[WB-1:0] = '1;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, output int ok);
    logic acc;
    ok = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int bp, output logic [W:0] res, output int ok);
    logic ov, ordy;
    ok = 0;
    res = '0;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ov = out_valid;
      ordy = out_ready;
      if (ov) res = {out_cout, out_sum};
      @(posedge clk);
      if (ov && ordy) begin
        ok = 1;
        break;
      end
      #1 out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1 out_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W:0]   res, res0, exp;
    logic [W-1:0] a, b, a2, b2;
    logic         cin, sub;
    int           ok, ok2, cnt;
    logic         stable, rdy_seen, ov_seen, busy_seen;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_result", {out_cout, out_sum}, 0);
    check("rst_adder_ops", {add_cin, add_a, add_b}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("idle_adder_ops", {add_cin, add_a, add_b}, 0);

    // all-ones + 1: full carry chain and latency
    out_ready = 1'b1;
    in_a = '1; in_b = 1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    cnt = 1;
    #1 in_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cnt == 1) check("run_word0_ops", {add_cin, add_a, add_b}, {1'b0, 32'hFFFF_FFFF, 32'h1});
      if (out_valid) break;
      @(posedge clk);
      cnt++;
    end
    check("latency_cycles", cnt, NW + 1);
    check("max_plus_one", {out_cout, out_sum}, {1'b1, {W{1'b0}}});
    @(posedge clk);
    @(negedge clk);
    check("after_handshake_ready", in_ready, 1);
    check("after_handshake_valid", out_valid, 0);

    // carry ripples through three words into the fourth
    a = 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    send(a, '0, 1'b1, 1'b0, ok);
    check("ripple_accept", ok, 1);
    collect(0, res, ok2);
    check("ripple_complete", ok2, 1);
    check("ripple_result", res, {1'b0, 128'h00000001_00000000_00000000_00000000});

    // hold in DONE with backpressure and a pending request
    out_ready = 1'b0;
    a = rand_wide(); b = rand_wide(); cin = 1'($urandom_range(0, 1));
    exp = ref_result(a, b, cin, 1'b0);
    send(a, b, cin, 1'b0, ok);
    check("hold_accept", ok, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    res0 = {out_cout, out_sum};
    check("hold_value", res0, exp);
    a2 = rand_wide(); b2 = rand_wide();
    in_a = a2; in_b = b2; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ({out_cout, out_sum} !== res0 || !out_valid) stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
    end
    check("hold_stable", stable, 1);
    check("hold_in_ready_low", rdy_seen, 0);
    // release while in_valid stays high: one idle bubble, then the new accept
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bubble_busy", busy, 0);
    check("bubble_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(0, res, ok2);
    check("bubble_next_complete", ok2, 1);
    check("bubble_next_result", res, ref_result(a2, b2, 1'b0, 1'b0));

    // reset in the middle of RUN
    a = rand_wide(); b = rand_wide();
    send(a, b, 1'b1, 1'b0, ok);
    check("midrst_accept", ok, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", {out_cout, out_sum}, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_adder_ops", {add_cin, add_a, add_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_release_ready", in_ready, 1);
    ov_seen = 1'b0;
    busy_seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    check("midrst_discarded", {busy_seen, ov_seen}, 0);
    a = rand_wide(); b = rand_wide(); cin = 1'($urandom_range(0, 1));
    send(a, b, cin, 1'b0, ok);
    check("fresh_accept", ok, 1);
    collect(0, res, ok2);
    check("fresh_complete", ok2, 1);
    check("fresh_result", res, ref_result(a, b, cin, 1'b0));

`ifdef WIDE_ADD_SEQ_SUB_EN
    send(128'd5, 128'd7, 1'b0, 1'b1, ok);
    collect(0, res, ok2);
    check("sub_5_7", res, {1'b0, {{(W-1){1'b1}}, 1'b0}});
    send(128'd7, 128'd5, 1'b0, 1'b1, ok);
    collect(0, res, ok2);
    check("sub_7_5", res, {1'b1, 128'd2});
`endif

    // randomized traffic with output backpressure
    for (int t = 0; t < 1000; t++) begin
      a = rand_wide(); b = rand_wide(); cin = 1'($urandom_range(0, 1));
`ifdef WIDE_ADD_SEQ_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      send(a, b, cin, sub, ok);
      check("rand_accept", ok, 1);
      exp_q.push_back(ref_result(a, b, cin, sub));
      collect(1, res, ok2);
      check("rand_complete", ok2, 1);
      check("rand_result", res, exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
